// File: rtl/tensor_pkg.sv
// Shared types and defaults for the tensor-core warp issue scheduler.
// Holds the per-warp state encoding and a helper for index widths.
package tensor_pkg;

    localparam int NUM_WARPS_DEFAULT = 8;
    localparam int THREAD_N_DEFAULT  = 4;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_LOADING = 3'd1,
        W_READY   = 3'd2,
        W_ISSUING = 3'd3,
        W_DRAIN   = 3'd4
    } warp_state_e;

    // clog2 that never collapses to a zero-width field
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tensor_issue_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer past the winner when the grant is consumed.
module rr_arbiter
    import tensor_pkg::*;
#(
    parameter int  NUM_WARPS = NUM_WARPS_DEFAULT,
    localparam int PTR_W     = width_min1(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] req,
    input  logic                 advance,
    output logic [NUM_WARPS-1:0] grant
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] nxt_ptr;
    logic             found;
    int               idx;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        nxt_ptr = ptr_q;
        idx     = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            for (int j = 0; j < NUM_WARPS; j++) begin
                if (!found && req[j] && (j == idx)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                    nxt_ptr  = (j == NUM_WARPS - 1) ? '0 : PTR_W'(j + 1);
                end
            end
        end
        ptr_d = (advance && found) ? nxt_ptr : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tensor_issue_sched.sv
// Warp issue scheduler: tracks operand loading per warp and streams one warp
// at a time through THREAD_N datapath steps, then waits for its writeback.
module tensor_issue_sched
    import tensor_pkg::*;
#(
    parameter int  NUM_WARPS = NUM_WARPS_DEFAULT,
    parameter int  THREAD_N  = THREAD_N_DEFAULT,
    localparam int WID_W     = width_min1(NUM_WARPS),
    localparam int STEP_W    = width_min1(THREAD_N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WID_W-1:0]     in_wid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 fire_valid,
    output logic [WID_W-1:0]     fire_wid,
    output logic [STEP_W-1:0]    fire_step,
    output logic                 fire_last,
    input  logic                 fire_ready,
    input  logic                 done_valid,
    input  logic [WID_W-1:0]     done_wid,
    output logic [NUM_WARPS-1:0] warp_busy,
    output logic                 err
);

    localparam int WID_SPAN = 1 << WID_W;

    logic                      fire_valid_q, fire_valid_d;
    logic [WID_W-1:0]          fire_wid_q, fire_wid_d;
    logic [STEP_W-1:0]         fire_step_q, fire_step_d;
    logic                      err_q, err_d;

    logic [NUM_WARPS-1:0]      ready_vec;
    logic [NUM_WARPS-1:0]      busy_vec;
    logic [NUM_WARPS-1:0]      grant;
    logic [WID_SPAN-1:0][2:0]  state_flat;
    logic [WID_W-1:0]          grant_wid;
    logic                      advance;
    logic                      fire_hs;
    logic                      fire_end;
    warp_state_e               in_state;
    warp_state_e               done_state;

    assign advance  = !fire_valid_q && (|ready_vec);
    assign fire_hs  = fire_valid_q && fire_ready;
    assign fire_end = fire_hs && (fire_step_q == STEP_W'(THREAD_N - 1));

    rr_arbiter #(
        .NUM_WARPS (NUM_WARPS)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (ready_vec),
        .advance (advance),
        .grant   (grant)
    );

    generate
        for (genvar gi = 0; gi < WID_SPAN; gi++) begin : g_warp
            if (gi < NUM_WARPS) begin : g_real
                warp_state_e st_q;
                warp_state_e st_d;

                // Each arm only fires from the state it owns, so same-cycle
                // beat/done/grant events for one warp never collide.
                always_comb begin
                    st_d = st_q;
                    case (st_q)
                        W_IDLE, W_LOADING: begin
                            if (in_valid && (in_wid == WID_W'(gi))) begin
                                st_d = in_last ? W_READY : W_LOADING;
                            end
                        end
                        W_READY: begin
                            if (advance && grant[gi]) begin
                                st_d = W_ISSUING;
                            end
                        end
                        W_ISSUING: begin
                            if (fire_end && (fire_wid_q == WID_W'(gi))) begin
                                st_d = W_DRAIN;
                            end
                        end
                        W_DRAIN: begin
                            if (done_valid && (done_wid == WID_W'(gi))) begin
                                st_d = W_IDLE;
                            end
                        end
                        default: st_d = W_IDLE;
                    endcase
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        st_q <= W_IDLE;
                    end else begin
                        st_q <= st_d;
                    end
                end

                assign state_flat[gi] = st_q;
                assign ready_vec[gi]  = (st_q == W_READY);
                assign busy_vec[gi]   = (st_q != W_IDLE);
            end else begin : g_pad
                // Unused warp ids look permanently busy: beats rejected, done flagged.
                assign state_flat[gi] = W_ISSUING;
            end
        end
    endgenerate

    always_comb begin
        in_state   = warp_state_e'(state_flat[in_wid]);
        done_state = warp_state_e'(state_flat[done_wid]);
    end

    assign in_ready = (in_state == W_IDLE) || (in_state == W_LOADING);
    assign err_d    = done_valid && (done_state != W_DRAIN);

    always_comb begin
        grant_wid = '0;
        for (int j = 0; j < NUM_WARPS; j++) begin
            if (grant[j]) begin
                grant_wid = WID_W'(j);
            end
        end
    end

    always_comb begin
        fire_valid_d = fire_valid_q;
        fire_wid_d   = fire_wid_q;
        fire_step_d  = fire_step_q;
        if (advance) begin
            fire_valid_d = 1'b1;
            fire_wid_d   = grant_wid;
            fire_step_d  = '0;
        end else if (fire_end) begin
            fire_valid_d = 1'b0;
        end else if (fire_hs) begin
            fire_step_d = fire_step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_valid_q <= 1'b0;
            fire_wid_q   <= '0;
            fire_step_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            fire_valid_q <= fire_valid_d;
            fire_wid_q   <= fire_wid_d;
            fire_step_q  <= fire_step_d;
            err_q        <= err_d;
        end
    end

    assign fire_valid = fire_valid_q;
    assign fire_wid   = fire_wid_q;
    assign fire_step  = fire_step_q;
    assign fire_last  = fire_valid_q && (fire_step_q == STEP_W'(THREAD_N - 1));
    assign warp_busy  = busy_vec;
    assign err        = err_q;

endmodule

// File: tb/tb_tensor_issue_sched.sv
// Directed bench for tensor_issue_sched: one task per scenario, inline checks,
// inputs driven and outputs sampled on the falling clock edge.
module tb_tensor_issue_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_wid = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       fire_valid;
    logic [2:0] fire_wid;
    logic [1:0] fire_step;
    logic       fire_last;
    logic       fire_ready = 1'b0;
    logic       done_valid = 1'b0;
    logic [2:0] done_wid = '0;
    logic [7:0] warp_busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    int order[$];
    int gap;
    bit prev_valid;

    tensor_issue_sched dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_wid     (in_wid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .fire_valid (fire_valid),
        .fire_wid   (fire_wid),
        .fire_step  (fire_step),
        .fire_last  (fire_last),
        .fire_ready (fire_ready),
        .done_valid (done_valid),
        .done_wid   (done_wid),
        .warp_busy  (warp_busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        done_valid = 1'b0;
        fire_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic beat(input int w, input bit last);
        in_valid = 1'b1;
        in_wid   = 3'(w);
        in_last  = last;
        #1;
        $display("beat wid=%0d last=%0b in_ready=%0b", w, last, in_ready);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_in_ready wid=%0d: got %0b expected 1", w, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic done_tx(input int w, input bit exp_err);
        done_valid = 1'b1;
        done_wid   = 3'(w);
        cycle();
        done_valid = 1'b0;
        $display("done wid=%0d err=%0b", w, err);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL done_err wid=%0d: got %0b expected %0b", w, err, exp_err);
        end
    endtask

    // Records the warp id at the first cycle of each tile and the bubble before it.
    task automatic watch(input int ntiles);
        int budget;
        budget = 60;
        while (order.size() < ntiles && budget > 0) begin
            if (fire_valid && !prev_valid) begin
                if (order.size() > 0) begin
                    checks++;
                    if (gap !== 1) begin
                        errors++;
                        $display("FAIL rr_bubble before wid=%0d: got %0d expected 1", fire_wid, gap);
                    end
                end
                order.push_back(int'(fire_wid));
                $display("tile start wid=%0d step=%0d", fire_wid, fire_step);
            end
            gap = fire_valid ? 0 : gap + 1;
            prev_valid = fire_valid;
            if (order.size() < ntiles) begin
                cycle();
                budget--;
            end
        end
        checks++;
        if (order.size() < ntiles) begin
            errors++;
            $display("FAIL rr_timeout: got %0d tiles expected %0d", order.size(), ntiles);
        end
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        checks++;
        if (fire_valid !== 1'b0) begin errors++; $display("FAIL reset_fire_valid: got %0b expected 0", fire_valid); end
        checks++;
        if (fire_last !== 1'b0) begin errors++; $display("FAIL reset_fire_last: got %0b expected 0", fire_last); end
        checks++;
        if (fire_step !== 2'd0 || fire_wid !== 3'd0) begin
            errors++; $display("FAIL reset_step_wid: got %0d/%0d expected 0/0", fire_step, fire_wid);
        end
        checks++;
        if (warp_busy !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL reset_busy_err: got %0h/%0b expected 00/0", warp_busy, err);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_tile();
        apply_reset();
        fire_ready = 1'b1;
        beat(3, 1'b0);
        beat(3, 1'b0);
        beat(3, 1'b1);
        checks++;
        if (warp_busy !== 8'h08 || fire_valid !== 1'b0) begin
            errors++; $display("FAIL single_ready: got busy=%0h valid=%0b expected 08/0", warp_busy, fire_valid);
        end
        cycle();
        for (int s = 0; s < 4; s++) begin
            $display("fire wid=%0d step=%0d last=%0b", fire_wid, fire_step, fire_last);
            checks++;
            if (fire_valid !== 1'b1 || fire_wid !== 3'd3 || fire_step !== 2'(s) || fire_last !== (s == 3)) begin
                errors++;
                $display("FAIL single_step%0d: got v=%0b w=%0d s=%0d l=%0b expected 1/3/%0d/%0b",
                         s, fire_valid, fire_wid, fire_step, fire_last, s, (s == 3));
            end
            cycle();
        end
        checks++;
        if (fire_valid !== 1'b0 || warp_busy !== 8'h08) begin
            errors++; $display("FAIL single_drain: got v=%0b busy=%0h expected 0/08", fire_valid, warp_busy);
        end
        done_tx(3, 1'b0);
        checks++;
        if (warp_busy !== 8'h00) begin errors++; $display("FAIL single_idle: got %0h expected 00", warp_busy); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        order.delete();
        gap = 0;
        prev_valid = 1'b0;
        beat(1, 1'b0);
        beat(5, 1'b0);
        beat(6, 1'b0);
        beat(1, 1'b1);
        beat(5, 1'b1);
        beat(6, 1'b1);
        fire_ready = 1'b1;
        watch(3);
        // Stall warp 6 while 0 then 7 become ready; the pointer now sits at 7.
        fire_ready = 1'b0;
        beat(0, 1'b1);
        beat(7, 1'b1);
        fire_ready = 1'b1;
        watch(5);
        checks++;
        if (order.size() !== 5) begin
            errors++; $display("FAIL rr_count: got %0d expected 5", order.size());
        end else begin
            int exp_order[5] = '{1, 5, 6, 7, 0};
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] !== exp_order[k]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]);
                end
            end
        end
        repeat (5) cycle();
        checks++;
        if (fire_valid !== 1'b0 || warp_busy !== 8'hE3) begin
            errors++; $display("FAIL rr_all_drain: got v=%0b busy=%0h expected 0/e3", fire_valid, warp_busy);
        end
        done_tx(0, 1'b0);
        done_tx(1, 1'b0);
        done_tx(5, 1'b0);
        done_tx(6, 1'b0);
        done_tx(7, 1'b0);
        checks++;
        if (warp_busy !== 8'h00) begin errors++; $display("FAIL rr_idle: got %0h expected 00", warp_busy); end
    endtask

    task automatic test_stall_and_errors();
        apply_reset();
        fire_ready = 1'b1;
        beat(2, 1'b1);
        cycle();
        cycle();
        cycle();
        fire_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_valid = 1'b1;
                in_wid   = 3'd2;
                in_last  = 1'b1;
                #1;
                $display("beat wid=2 last=1 in_ready=%0b (issuing)", in_ready);
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL issuing_in_ready: got %0b expected 0", in_ready); end
            end
            checks++;
            if (fire_valid !== 1'b1 || fire_step !== 2'd2 || fire_wid !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%0b s=%0d w=%0d expected 1/2/2", k, fire_valid, fire_step, fire_wid);
            end
            cycle();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        fire_ready = 1'b1;
        cycle();
        checks++;
        if (fire_step !== 2'd3 || fire_last !== 1'b1 || fire_wid !== 3'd2) begin
            errors++; $display("FAIL stall_release: got s=%0d l=%0b w=%0d expected 3/1/2", fire_step, fire_last, fire_wid);
        end
        cycle();
        cycle();
        checks++;
        if (fire_valid !== 1'b0 || warp_busy !== 8'h04) begin
            errors++; $display("FAIL stall_no_reissue: got v=%0b busy=%0h expected 0/04", fire_valid, warp_busy);
        end
        done_tx(4, 1'b1);
        checks++;
        if (warp_busy !== 8'h04) begin errors++; $display("FAIL err_no_change: got %0h expected 04", warp_busy); end
        cycle();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %0b expected 0", err); end
        done_tx(2, 1'b0);
        checks++;
        if (warp_busy !== 8'h00) begin errors++; $display("FAIL stall_idle: got %0h expected 00", warp_busy); end
    endtask

    task automatic test_done_with_beat();
        apply_reset();
        fire_ready = 1'b1;
        beat(0, 1'b1);
        repeat (5) cycle();
        checks++;
        if (warp_busy !== 8'h01 || fire_valid !== 1'b0) begin
            errors++; $display("FAIL db_drain: got busy=%0h v=%0b expected 01/0", warp_busy, fire_valid);
        end
        in_valid   = 1'b1;
        in_wid     = 3'd0;
        in_last    = 1'b0;
        done_valid = 1'b1;
        done_wid   = 3'd0;
        #1;
        $display("done wid=0 with beat wid=0 in_ready=%0b", in_ready);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL db_in_ready: got %0b expected 0", in_ready); end
        cycle();
        in_valid   = 1'b0;
        done_valid = 1'b0;
        checks++;
        if (warp_busy !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL db_idle: got busy=%0h err=%0b expected 00/0", warp_busy, err);
        end
        beat(0, 1'b0);
        checks++;
        if (warp_busy !== 8'h01) begin errors++; $display("FAIL db_resend: got %0h expected 01", warp_busy); end
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        fire_ready = 1'b1;
        beat(7, 1'b1);
        cycle();
        cycle();
        checks++;
        if (fire_valid !== 1'b1 || fire_step !== 2'd1 || fire_wid !== 3'd7) begin
            errors++; $display("FAIL mid_pre: got v=%0b s=%0d w=%0d expected 1/1/7", fire_valid, fire_step, fire_wid);
        end
        reset  = 1'b1;
        in_wid = 3'd7;
        cycle();
        #1;
        checks++;
        if (fire_valid !== 1'b0 || fire_step !== 2'd0 || fire_wid !== 3'd0 || fire_last !== 1'b0 ||
            err !== 1'b0 || warp_busy !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b s=%0d w=%0d l=%0b e=%0b busy=%0h rdy=%0b expected 0/0/0/0/0/00/1",
                     fire_valid, fire_step, fire_wid, fire_last, err, warp_busy, in_ready);
        end
        reset = 1'b0;
        cycle();
        cycle();
        checks++;
        if (fire_valid !== 1'b0 || err !== 1'b0 || warp_busy !== 8'h00) begin
            errors++; $display("FAIL mid_after: got v=%0b e=%0b busy=%0h expected 0/0/00", fire_valid, err, warp_busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_tile();
        test_round_robin();
        test_stall_and_errors();
        test_done_with_beat();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
